// File: rtl/hazard_pkg.sv
// Shared types and helpers for the LEGv8 pipeline hazard controller.
package hazard_pkg;

    // One scoreboard slot: a destination register in flight in one stage.
    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
    } sb_entry_t;

    // X31 reads as zero and discards writes, so it never carries a dependence.
    localparam logic [4:0] XZR = 5'd31;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dst: 5'd0};

    // True when a read source depends on the register held in this slot.
    function automatic logic sb_match(input sb_entry_t  entry,
                                      input logic [4:0] src,
                                      input logic       use_src);
        return use_src & (src != XZR) & entry.valid & (entry.dst == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sb_stage.sv
// One registered scoreboard slot with a synchronous clear.
module sb_stage
    import hazard_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_clr,
    input  sb_entry_t i_d,
    output sb_entry_t o_q
);

    sb_entry_t r_q;

    // Load the upstream entry each cycle; reset or clear empties the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= SB_EMPTY;
        end else if (i_clr) begin
            r_q <= SB_EMPTY;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and flush sequencer for the 5-stage LEGv8 pipeline (no forwarding).
// Tracks destinations in flight in EX/MEM/WB, stalls fetch/decode on a RAW
// dependence and flushes the younger stages on a branch taken in MEM.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int N         = 64,
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       src1_D,
    input  logic [4:0]       src2_D,
    input  logic             src1_use_D,
    input  logic             src2_use_D,
    input  logic [4:0]       dst_D,
    input  logic             regWrite_D,
    input  logic             valid_D,
    input  logic             PCSrc_M,
    output logic             stall_F,
    output logic             stall_D,
    output logic             bubble_E,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    sb_entry_t w_issue;
    sb_entry_t w_sb_e;
    sb_entry_t w_sb_m;
    sb_entry_t w_sb_w;
    logic      w_match1;
    logic      w_match2;
    logic      w_hazard;
    logic      w_stall;
    logic      w_flush;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Entry the decode instruction would occupy in EX; XZR writes are ignored.
    assign w_issue.valid = valid_D & regWrite_D & (dst_D != XZR);
    assign w_issue.dst   = dst_D;

    // Source-versus-scoreboard compare; the WB slot only matters without write-through.
    always_comb begin
        w_match1 = sb_match(w_sb_e, src1_D, src1_use_D)
                 | sb_match(w_sb_m, src1_D, src1_use_D);
        w_match2 = sb_match(w_sb_e, src2_D, src2_use_D)
                 | sb_match(w_sb_m, src2_D, src2_use_D);
        if (!WB_BYPASS) begin
            w_match1 = w_match1 | sb_match(w_sb_w, src1_D, src1_use_D);
            w_match2 = w_match2 | sb_match(w_sb_w, src2_D, src2_use_D);
        end else begin
            w_match1 = w_match1;
            w_match2 = w_match2;
        end
        w_hazard = valid_D & (w_match1 | w_match2);
    end

    // A taken branch outranks a stall: the stalled instruction is being discarded anyway.
    always_comb begin
        w_flush  = PCSrc_M;
        w_stall  = 1'b0;
        if (PCSrc_M) begin
            w_stall = 1'b0;
        end else begin
            w_stall = w_hazard;
        end
        stall_F  = w_stall;
        stall_D  = w_stall;
        bubble_E = w_stall;
        flush_D  = w_flush;
        flush_E  = w_flush;
        flush_M  = w_flush;
    end

    // EX slot takes the issue entry, or a bubble on stall/flush.
    sb_stage u_sb_e (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_stall | w_flush),
        .i_d   (w_issue),
        .o_q   (w_sb_e)
    );

    // MEM slot follows EX, emptied when EX/MEM is flushed.
    sb_stage u_sb_m (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_flush),
        .i_d   (w_sb_e),
        .o_q   (w_sb_m)
    );

    // WB slot always follows MEM; on a flush that is the branch itself.
    sb_stage u_sb_w (
        .clk   (clk),
        .reset (reset),
        .i_clr (1'b0),
        .i_d   (w_sb_m),
        .o_q   (w_sb_w)
    );

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    // Saturating taken-branch flush counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_cnt <= {CNT_W{1'b0}};
        end else if (w_flush && (r_flush_cnt != CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end else begin
            r_flush_cnt <= r_flush_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and flush sequencer for the 5-stage LEGv8 pipelined datapath. It keeps a registered scoreboard of destination registers in flight in EX, MEM and WB, and stalls fetch/decode while a decode-stage source depends on one of them (the datapath has no forwarding). It flushes the younger stages when a branch resolves taken in MEM and counts stall and flush cycles for performance readout. It sits beside `datapath`, driving the enables and clears of the PC and of the IF/ID, ID/EX and EX/MEM registers.

## Interface
- `N`, 64: datapath width; carried for consistency, not used internally.
- `WB_BYPASS`, 1: 1 = register file is write-through in the WB cycle, so a WB-stage match is not a hazard; 0 = a WB match stalls.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `src1_D` in 5: Rn of the decode instruction.
- `src2_D` in 5: second source, already muxed by `reg2loc`.
- `src1_use_D` in 1: src1 is read.
- `src2_use_D` in 1: src2 is read.
- `dst_D` in 5: Rd/Rt of the decode instruction.
- `regWrite_D` in 1: decode instruction writes a register.
- `valid_D` in 1: IF/ID holds a real instruction.
- `PCSrc_M` in 1: branch taken, resolved in MEM.
- `stall_F` out 1: hold PC.
- `stall_D` out 1: hold IF/ID.
- `bubble_E` out 1: ID/EX loads zero control.
- `flush_D` out 1: clear IF/ID.
- `flush_E` out 1: clear ID/EX.
- `flush_M` out 1: clear EX/MEM.
- `stall_cnt` out CNT_W: stall cycles seen.
- `flush_cnt` out CNT_W: taken-branch flushes.

## Operation
- Scoreboard: three entries `sb_E`, `sb_M`, `sb_W`, each {valid, dst[4:0]}. Together they mirror ID/EX, EX/MEM and MEM/WB.
- Issue entry: valid = `valid_D & regWrite_D & (dst_D != 31)`, dst = `dst_D`. X31 (XZR) never creates or matches a hazard.
- Match: `srcX_use_D` and `srcX_D != 31`, and equal to a valid dst in `sb_E` or `sb_M`. `sb_W` also counts when `WB_BYPASS = 0`.
- `hazard = valid_D & (match1 | match2)`.
- Normal cycle: `sb_E` ← issue entry, `sb_M` ← `sb_E`, `sb_W` ← `sb_M`.
- Stall cycle (hazard, no flush):
  - `stall_F = stall_D = bubble_E = 1`.
  - `sb_E` ← invalid, and `sb_M`/`sb_W` shift as normal.
  - `stall_cnt` +1.
- Flush cycle (`PCSrc_M`):
  - `flush_D = flush_E = flush_M = 1`.
  - `sb_E` ← invalid, `sb_M` ← invalid (the cleared EX/MEM slot), `sb_W` ← `sb_M`, which is the branch (no dst).
  - `flush_cnt` +1.
- Flush has priority over a simultaneous hazard: stall outputs are 0 and `stall_cnt` is not incremented.
- Counters saturate at all-ones and never wrap.
- No FSM beyond the scoreboard shift; the block is stateless apart from the scoreboard and counters.

## Timing
- Reset: all scoreboard entries invalid, all control outputs 0, both counters 0. The effect is visible the cycle after `reset` is sampled high. Reset mid-stall or mid-flush drops the event immediately; no residue.
- All control outputs are combinational from the current D inputs plus the registered scoreboard, and valid in the same cycle. Counters are registered, so they update one cycle after the event.
- Back-to-back dependence (producer directly ahead of consumer):
  - 2 stall cycles with `WB_BYPASS = 1`.
  - 3 stall cycles with `WB_BYPASS = 0`.
  - One intervening instruction reduces the stall by 1.
- The stall deasserts in the cycle the producer leaves the last checked stage. The consumer then advances on the next edge.
- Load-use needs no special case: loads write back through WB like ALU ops.

## Structure
- Package `hazard_pkg`:
  - typedef `sb_entry_t` {logic valid; logic [4:0] dst}.
  - constant `XZR = 5'd31`.
  - function `sb_match(entry, src, use)`.
- One sub-module, `sb_stage`: a registered `sb_entry_t` with a clear input, instantiated three times.
- Integration: IF/ID, ID/EX and EX/MEM move from plain `flopr` to an enable/clear variant. The PC register gains an enable.

## Test plan
- Independent ops: `ADD X1,X2,X3` then `ADD X4,X5,X6` → no stall, `stall_cnt` stays 0.
- Back-to-back RAW: `ADD X1,X2,X3` then `SUB X4,X1,X5`, `WB_BYPASS = 1` → `stall_F/D` and `bubble_E` high for exactly 2 cycles, then `stall_cnt = 2`. With `WB_BYPASS = 0` → 3 cycles.
- XZR: `ADD XZR,X2,X3` then `ADD X4,XZR,X5` → no stall.
- Load then store: `LDUR X9,[X0,#0]` then `STUR X9,[X1,#8]`, src2 via `reg2loc` → 2-cycle stall.
- Simultaneous events: `PCSrc_M = 1` in the same cycle as a hazard → flush outputs high, stall outputs low, `flush_cnt` +1, `stall_cnt` unchanged, `sb_E`/`sb_M` invalid next cycle.
- Reset and saturation:
  - Assert `reset` during the second stall cycle → next cycle all outputs 0, counters 0.
  - With `CNT_W = 4`, 20 consecutive stalls → `stall_cnt` holds at 15.
